// File: rtl/reflet_timer_pkg.sv
// Shared constants for the reflet_timer peripheral: register offsets, CTRL bit
// positions and the size of the decoded address window.
package reflet_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_CAPTURE  = 3'd4;

  localparam int CTRL_RUN         = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int CTRL_PENDING     = 3;

  localparam int WINDOW_SIZE = 5;

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Prescaler for reflet_timer: counts 0..limit while running and emits a
// one-cycle tick on the cycle the counter sits at limit.
module reflet_timer_prescaler #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                run,
  input  logic                clear,
  input  logic [wordsize-1:0] limit,
  output logic                tick
);

  logic [wordsize-1:0] cnt;

  assign tick = enable && run && (cnt == limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (enable) begin
      if (clear) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= (cnt == limit) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped timer on the reflet_cpu data bus: prescaled counter, compare
// match interrupt. Define REFLET_TIMER_CAPTURE_EN to map the CAPTURE register.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int          wordsize  = 16,
  parameter int unsigned base_addr = 'h80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  localparam logic [wordsize-1:0] BASE = wordsize'(base_addr);
  localparam logic [wordsize-1:0] WIN  = wordsize'(WINDOW_SIZE);

  logic [wordsize-1:0] offset;
  logic                in_window;
  logic [2:0]          sel;
  logic                wr;

  logic                run, irq_en, auto_reload, pending;
  logic [wordsize-1:0] prescale, compare, count;
  logic                tick, match, pre_clear;
  logic [wordsize-1:0] rd_mux, rd_data_p1;

  // Addresses below base wrap to large offsets and fall outside the window.
  assign offset    = addr - BASE;
  assign in_window = offset < WIN;
  assign sel       = offset[2:0];
  assign wr        = enable && write_en && in_window;
  assign match     = (count == compare);

  assign pre_clear = wr && ((sel == REG_PRESCALE) || (sel == REG_COUNT) ||
                            ((sel == REG_CTRL) && data_in[CTRL_RUN] && !run));

  reflet_timer_prescaler #(.wordsize(wordsize)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .run    (run),
    .clear  (pre_clear),
    .limit  (prescale),
    .tick   (tick)
  );

  // Stage p0: tick update first, CPU writes afterwards so they take priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run         <= 1'b0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      pending     <= 1'b0;
      prescale    <= '0;
      compare     <= '0;
      count       <= '0;
    end else if (enable) begin
      if (tick) begin
        if (match) begin
          pending <= 1'b1;
          if (auto_reload) count <= '0;
          else             run   <= 1'b0;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (wr) begin
        case (sel)
          REG_CTRL: begin
            run         <= data_in[CTRL_RUN];
            irq_en      <= data_in[CTRL_IRQ_EN];
            auto_reload <= data_in[CTRL_AUTO_RELOAD];
            // A match on the same edge keeps pending set.
            if (data_in[CTRL_PENDING] && !(tick && match)) pending <= 1'b0;
          end
          REG_PRESCALE: prescale <= data_in;
          REG_COMPARE:  compare  <= data_in;
          REG_COUNT:    count    <= data_in;
          default: ;
        endcase
      end
    end
  end

`ifdef REFLET_TIMER_CAPTURE_EN
  logic [wordsize-1:0] capture;

  always_ff @(posedge clk) begin
    if (!reset) begin
      capture <= '0;
    end else if (wr && (sel == REG_CAPTURE)) begin
      capture <= count;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (in_window) begin
      case (sel)
        REG_CTRL: begin
          rd_mux[CTRL_RUN]         = run;
          rd_mux[CTRL_IRQ_EN]      = irq_en;
          rd_mux[CTRL_AUTO_RELOAD] = auto_reload;
          rd_mux[CTRL_PENDING]     = pending;
        end
        REG_PRESCALE: rd_mux = prescale;
        REG_COMPARE:  rd_mux = compare;
        REG_COUNT:    rd_mux = count;
`ifdef REFLET_TIMER_CAPTURE_EN
        REG_CAPTURE:  rd_mux = capture;
`endif
        default:      rd_mux = '0;
      endcase
    end
  end

  // Stage p1: registered read data, frozen while enable is low.
  always_ff @(posedge clk) begin
    if (!reset)      rd_data_p1 <= '0;
    else if (enable) rd_data_p1 <= rd_mux;
  end

  assign data_out = rd_data_p1;
  assign irq      = pending && irq_en;

endmodule
